if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-memory
//  request handshake and presents {pc_4_out, instr_out, valid_out} to the IF-ID pipeline register.
//  Handles multi-cycle memory latency, downstream stalls and branch/jump redirects, including a
//  redirect that arrives while a fetch is still outstanding.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset (low 2 bits must be 0)
//  NOP_INSTR  32'h0000_0000  instr_out value whenever valid_out=0 (MIPS sll $0,$0,0)
// PORTS
//  clk             in   1   clock, all state updates on rising edge
//  rst_n           in   1   reset, asynchronous, active-low
//  imem_req        out  1   fetch request to instruction memory
//  imem_addr       out  32  fetch address (= current PC), word aligned
//  imem_ready      in   1   memory accepts/completes request this cycle; imem_rdata valid same cycle
//  imem_rdata      in   32  fetched instruction word
//  stall_in        in   1   1 = downstream (IF-ID) cannot accept this cycle
//  redirect_in     in   1   1 = branch/jump taken; discard in-flight fetch, restart at redirect_pc_in
//  redirect_pc_in  in   32  redirect target; bits[1:0] ignored (treated as 0)
//  pc_4_out        out  32  PC+4 of the instruction on instr_out
//  instr_out       out  32  fetched instruction, NOP_INSTR when valid_out=0
//  valid_out       out  1   instr_out/pc_4_out hold a real instruction
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, state=FETCH, hold buffer cleared; imem_req=0 and valid_out=0
//   while rst_n=0; an outstanding request is abandoned. First request in the first cycle after release.
//  Memory protocol: imem_req=1 with imem_addr stable until a cycle with imem_ready=1; zero-wait
//   memory (ready tied 1) must sustain 1 instr/cycle.
//  Handoff: an instruction is consumed when valid_out=1 && stall_in=0 && redirect_in=0.
//  States:
//   FETCH: imem_req=1, imem_addr=pc. valid_out = imem_ready && !redirect_in (combinational pass-through,
//    instr_out=imem_rdata, pc_4_out=pc+4).
//     redirect_in              -> pc<=redirect_pc_in; if imem_ready stay FETCH (data discarded),
//                                 else save target, go DROP.
//     ready && !stall_in       -> pc<=pc+4, stay FETCH.
//     ready &&  stall_in       -> capture rdata into hold buffer, go HOLD.
//     !ready                   -> stay FETCH, nothing changes.
//   HOLD: imem_req=0; valid_out=1, instr_out=hold buffer, pc_4_out=pc+4.
//     redirect_in              -> discard buffer, pc<=redirect_pc_in, go FETCH.
//     !stall_in                -> pc<=pc+4, go FETCH (next request next cycle).
//     stall_in                 -> stay HOLD, outputs unchanged.
//   DROP: imem_req=1 at old addr (must finish handshake); valid_out=0.
//     imem_ready               -> discard data, pc<=saved target, go FETCH.
//     redirect_in (any ready)  -> overwrite saved target (newest redirect wins); ready rule above still applies.
//  Priority: reset > redirect_in > stall_in. Redirect never emits the discarded instruction.
//  Arithmetic: pc+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); pc[1:0] always 0.
//  valid_out=0 => instr_out=NOP_INSTR, pc_4_out=pc+4 (don't-care to consumer but deterministic).
// TESTING
//  1 Zero-wait mem (ready=1), RESET_PC=0, no stall: consecutive cycles present pc_4_out 4,8,12,... one per cycle.
//  2 ready asserted every 3rd cycle: imem_addr stable across wait cycles; valid_out pulses only on ready cycles.
//  3 stall_in=1 for 4 cycles as ready returns 0x8C220004: HOLD keeps instr_out=0x8C220004, imem_req=0;
//    after release next imem_addr = old pc+4, no instruction lost or duplicated.
//  4 redirect_in to 0x0000_0100 while request pending (ready=0, 2 more wait cycles): old data discarded,
//    valid_out=0 through DROP, next imem_addr=0x100; redirect_pc 0x103 also yields 0x100.
//  5 redirect_in and stall_in in same cycle while in HOLD: buffer dropped, next fetch at target, no stale valid_out.
//  6 pc=0xFFFF_FFFC fetch completes -> pc_4_out=0, next imem_addr=0; rst_n low mid-wait -> imem_req=0 same cycle,
//    fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// The master issues req/addr and the slave returns ready/rdata in the same cycle.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: owns the PC and runs the imem handshake. It presents fetched words to IF-ID,
// with a hold buffer for downstream stalls and a drop state for redirects that hit a pending fetch.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  if_fetch_stage_if.master        imem,
  input  logic                    stall_in,
  input  logic                    redirect_in,
  input  logic [31:0]             redirect_pc_in,
  output logic [31:0]             pc_4_out,
  output logic [31:0]             instr_out,
  output logic                    valid_out
);

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_HOLD  = 2'b01,
    S_DROP  = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] target_q, target_d;

  logic        req_s;
  logic        valid_s;
  logic [31:0] instr_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] redirect_pc_s;

  assign pc_plus4_s    = pc_q + 32'd4;
  assign redirect_pc_s = redirect_pc_in & 32'hFFFF_FFFC;

  // State register: reset abandons any outstanding request and restarts at RESET_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC & 32'hFFFF_FFFC;
      hold_q   <= NOP_INSTR;
      target_q <= RESET_PC & 32'hFFFF_FFFC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      hold_q   <= hold_d;
      target_q <= target_d;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hold_d   = hold_q;
    target_d = target_q;
    req_s    = 1'b0;
    valid_s  = 1'b0;
    instr_s  = NOP_INSTR;

    case (state_q)
      S_FETCH: begin
        req_s = 1'b1;
        if (redirect_in) begin
          if (imem.imem_ready) begin
            pc_d = redirect_pc_s;
          end else begin
            // pc keeps the old address so imem_addr stays stable until the drop completes
            target_d = redirect_pc_s;
            state_d  = S_DROP;
          end
        end else if (imem.imem_ready) begin
          valid_s = 1'b1;
          instr_s = imem.imem_rdata;
          if (stall_in) begin
            hold_d  = imem.imem_rdata;
            state_d = S_HOLD;
          end else begin
            pc_d = pc_plus4_s;
          end
        end else begin
          state_d = S_FETCH;
        end
      end

      S_HOLD: begin
        valid_s = 1'b1;
        instr_s = hold_q;
        if (redirect_in) begin
          hold_d  = NOP_INSTR;
          pc_d    = redirect_pc_s;
          state_d = S_FETCH;
        end else if (!stall_in) begin
          pc_d    = pc_plus4_s;
          state_d = S_FETCH;
        end else begin
          state_d = S_HOLD;
        end
      end

      S_DROP: begin
        req_s = 1'b1;
        if (imem.imem_ready) begin
          pc_d     = redirect_in ? redirect_pc_s : target_q;
          target_d = redirect_in ? redirect_pc_s : target_q;
          state_d  = S_FETCH;
        end else if (redirect_in) begin
          target_d = redirect_pc_s;
        end else begin
          state_d = S_DROP;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign imem.imem_addr = pc_q;
  assign pc_4_out       = pc_plus4_s;

  // Reset forces the request and the IF-ID view idle without waiting for a clock.
  always_comb begin
    if (rst_n) begin
      imem.imem_req = req_s;
      valid_out     = valid_s;
      instr_out     = instr_s;
    end else begin
      imem.imem_req = 1'b0;
      valid_out     = 1'b0;
      instr_out     = NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: program-order reference model plus directed literals
// and randomized ready/stall/redirect traffic.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready_drv = 1'b0;
  logic        stall_in = 1'b0;
  logic        redirect_in = 1'b0;
  logic [31:0] redirect_pc_in = 32'h0000_0000;
  logic [31:0] pc_4_out;
  logic [31:0] instr_out;
  logic        valid_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0000_0040) return 32'h8C22_0004;
    return {~addr[15:0], addr[15:0]} ^ 32'h1357_9BDF;
  endfunction

  if_fetch_stage_if imem_bus();
  assign imem_bus.imem_ready = ready_drv;
  assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

  if_fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem_bus),
    .stall_in       (stall_in),
    .redirect_in    (redirect_in),
    .redirect_pc_in (redirect_pc_in),
    .pc_4_out       (pc_4_out),
    .instr_out      (instr_out),
    .valid_out      (valid_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the next instruction owed to IF-ID in program order, plus handshake memory.
  logic [31:0] m_pc;
  logic [31:0] m_prev_addr;
  logic        m_drop;
  logic        m_prev_wait;
  logic        m_prev_blocked;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
      check("rst_valid", {31'd0, valid_out}, 32'd0);
      check("rst_instr", instr_out, NOP);
      m_pc           <= 32'h0000_0000;
      m_drop         <= 1'b0;
      m_prev_wait    <= 1'b0;
      m_prev_blocked <= 1'b0;
      m_prev_addr    <= 32'h0000_0000;
    end else begin
      if (m_prev_wait) begin
        check("req_held", {31'd0, imem_bus.imem_req}, 32'd1);
        check("addr_stable", imem_bus.imem_addr, m_prev_addr);
      end
      if (m_prev_blocked) begin
        check("hold_no_req", {31'd0, imem_bus.imem_req}, 32'd0);
        check("hold_valid", {31'd0, valid_out}, 32'd1);
      end
      if (m_drop) check("drop_no_valid", {31'd0, valid_out}, 32'd0);
      if (!valid_out) check("nop_when_invalid", instr_out, NOP);
      if (valid_out) begin
        check("order_pc4", pc_4_out, m_pc + 32'd4);
        check("order_instr", instr_out, mem_word(m_pc));
      end
      if (imem_bus.imem_req && ready_drv && !m_drop && !redirect_in)
        check("fetch_addr", imem_bus.imem_addr, m_pc);

      if (imem_bus.imem_req && !ready_drv && redirect_in) m_drop <= 1'b1;
      else if (imem_bus.imem_req && ready_drv)            m_drop <= 1'b0;

      if (redirect_in)                 m_pc <= redirect_pc_in & 32'hFFFF_FFFC;
      else if (valid_out && !stall_in) m_pc <= m_pc + 32'd4;

      m_prev_wait    <= imem_bus.imem_req && !ready_drv;
      m_prev_addr    <= imem_bus.imem_addr;
      m_prev_blocked <= valid_out && stall_in && !redirect_in;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    repeat (3) tick();
    // zero-wait stream from RESET_PC
    ready_drv = 1'b1;
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      sample();
      check("t1_pc4", pc_4_out, 32'(4 * k));
      check("t1_valid", {31'd0, valid_out}, 32'd1);
      tick();
    end

    // ready every third cycle
    for (int i = 0; i < 9; i++) begin
      ready_drv = (i % 3 == 2);
      sample();
      check("t2_valid", {31'd0, valid_out}, {31'd0, (i % 3 == 2)});
      tick();
    end

    // stall while 0x8C220004 returns
    redirect_in = 1'b1; redirect_pc_in = 32'h0000_0040; ready_drv = 1'b1;
    tick();
    redirect_in = 1'b0; stall_in = 1'b1;
    sample();
    check("t3_instr0", instr_out, 32'h8C22_0004);
    tick();
    ready_drv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("t3_req", {31'd0, imem_bus.imem_req}, 32'd0);
      check("t3_instr", instr_out, 32'h8C22_0004);
      tick();
    end
    stall_in = 1'b0;
    tick();
    ready_drv = 1'b1;
    sample();
    check("t3_next_addr", imem_bus.imem_addr, 32'h0000_0044);
    tick();

    // redirect during a pending fetch, newest redirect wins, low bits ignored
    ready_drv = 1'b0; redirect_in = 1'b1; redirect_pc_in = 32'h0000_0200;
    tick();
    redirect_pc_in = 32'h0000_0103;
    sample();
    check("t4_drop_addr", imem_bus.imem_addr, 32'h0000_0048);
    tick();
    redirect_in = 1'b0; ready_drv = 1'b1;
    sample();
    check("t4_drop_valid", {31'd0, valid_out}, 32'd0);
    tick();
    ready_drv = 1'b0;
    sample();
    check("t4_target_addr", imem_bus.imem_addr, 32'h0000_0100);
    tick();

    // redirect and stall together while holding
    ready_drv = 1'b1; stall_in = 1'b1;
    tick();
    ready_drv = 1'b0; redirect_in = 1'b1; redirect_pc_in = 32'h0000_0300;
    tick();
    redirect_in = 1'b0; stall_in = 1'b0;
    sample();
    check("t5_valid", {31'd0, valid_out}, 32'd0);
    check("t5_addr", imem_bus.imem_addr, 32'h0000_0300);
    tick();

    // PC wrap, then reset in the middle of a wait
    redirect_in = 1'b1; redirect_pc_in = 32'hFFFF_FFFC; ready_drv = 1'b1;
    tick();
    redirect_in = 1'b0;
    sample();
    check("t6_wrap_pc4", pc_4_out, 32'h0000_0000);
    tick();
    ready_drv = 1'b0;
    sample();
    check("t6_wrap_addr", imem_bus.imem_addr, 32'h0000_0000);
    tick();
    redirect_in = 1'b1; redirect_pc_in = 32'h0000_0500; ready_drv = 1'b1;
    tick();
    redirect_in = 1'b0; ready_drv = 1'b0;
    tick();
    sample();
    check("t6_wait_addr", imem_bus.imem_addr, 32'h0000_0500);
    #1 rst_n = 1'b0;
    #1 check("t6_rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    sample();
    check("t6_restart_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check("t6_restart_addr", imem_bus.imem_addr, 32'h0000_0000);
    tick();

    // randomized traffic, ready density varying per segment
    for (int seg = 0; seg < 6; seg++) begin
      for (int c = 0; c < 500; c++) begin
        ready_drv      = ($urandom_range(0, 9) < ((seg % 3 == 0) ? 10 : (seg % 3 == 1) ? 6 : 3));
        stall_in       = ($urandom_range(0, 3) == 0);
        redirect_in    = ($urandom_range(0, 11) == 0);
        redirect_pc_in = $urandom();
        rst_n          = ($urandom_range(0, 299) != 0);
        tick();
      end
    end
    rst_n = 1'b1; redirect_in = 1'b0; stall_in = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
